ctrlunit_mc: RTL and testbench
==============================

CTRLUNIT_MC -- requirements
Module: ctrlunit_mc

Interface
REQ-001 The block SHALL have parameter OP_W, default 4, meaning the opcode width (legal values 3..6).
REQ-002 The block SHALL have parameter TMO_W, default 4, meaning the width of the memory wait-timeout counter.
REQ-003 The block SHALL have port clk_i, input, width 1, meaning the single clock; all state changes occur on its rising edge.
REQ-004 The block SHALL have port rst_i, input, width 1, meaning reset; it is asynchronous and active-high.
REQ-005 The block SHALL have port run_i, input, width 1, meaning start execution from IDLE.
REQ-006 The block SHALL have port op_i, input, width OP_W, meaning the opcode from the instruction register.
REQ-007 The block SHALL have ports zf_i and cf_i, input, width 1 each, meaning the ALU zero and carry flags.
REQ-008 The block SHALL have port mem_rdy_i, input, width 1, meaning the memory access completes this cycle.
REQ-009 The block SHALL have ports mr_o, mw_o, ir_ld_o, pc_inc_o, jmp_o and acc_ld_o, output, width 1 each, meaning read, write, IR load, PC increment, PC load and accumulator load.
REQ-010 The block SHALL have port alu_op_o, output, width 2, meaning the ALU operation: 00 PASS, 01 ADD, 10 SUB, 11 AND.
REQ-011 The block SHALL have ports halt_o and err_o, output, width 1 each, meaning halted and bus-timeout error.
REQ-012 The block SHALL have port state_o, output, width 3, meaning the current FSM state encoding, for debug.

Function
REQ-013 The FSM SHALL have the states IDLE=0, FETCH=1, DECODE=2, EXEC=3, WB=4 and HALT=5; codes 6 and 7 SHALL go to HALT with err_o=1.
REQ-014 In IDLE, all strobes SHALL be 0; run_i=1 SHALL move the FSM to FETCH on the next edge.
REQ-015 In FETCH, mr_o=1 and ir_ld_o=1; on mem_rdy_i=1 the FSM SHALL assert pc_inc_o=1 in that same cycle and go to DECODE.
REQ-016 DECODE SHALL last exactly one cycle, capture op_i into op_q, and go to EXEC.
REQ-017 Opcode map for op_q (upper bits zero): 0 ADD, 1 SUB, 2 LDA, 3 STA, 4 JMP, 5 JZ, 6 JC, 7 HLT, 8 AND; any other code SHALL be a NOP that returns to FETCH.
REQ-018 For ADD, SUB, AND and LDA, EXEC SHALL hold mr_o=1 until mem_rdy_i=1, then go to WB; WB SHALL assert acc_ld_o=1 and alu_op_o (PASS for LDA) for one cycle, then go to FETCH.
REQ-019 For STA, EXEC SHALL hold mw_o=1 until mem_rdy_i=1, then go to FETCH.
REQ-020 For JMP, EXEC SHALL assert jmp_o=1 for one cycle; for JZ and JC, jmp_o SHALL equal zf_i and cf_i respectively, sampled in EXEC; the FSM SHALL then go to FETCH.
REQ-021 For HLT, the FSM SHALL go from EXEC to HALT; HALT SHALL hold halt_o=1 with all strobes 0 until reset.
REQ-022 Zero-wait latency SHALL be 4 cycles for ALU and LDA instructions, and 3 cycles for STA, jump and NOP instructions.
REQ-023 mr_o and mw_o SHALL never be 1 in the same cycle; when the strobes are unused, alu_op_o SHALL be 00.
REQ-024 All outputs SHALL be decoded combinationally from the state and op_q, except pc_inc_o and jmp_o, which also depend on mem_rdy_i and the flags as stated above.

Reset
REQ-025 While rst_i=1, the FSM SHALL be in IDLE, op_q=0, the timeout counter=0, and every output 0 (state_o=0), regardless of the clock.
REQ-026 Reset asserted mid-instruction SHALL abort the instruction at once with no further strobes; deassertion SHALL require run_i to restart.

Configuration
REQ-027 With CTRLUNIT_MC_WAIT_EN defined, a TMO_W-bit counter SHALL count consecutive cycles with mem_rdy_i=0 in FETCH or EXEC; on reaching all-ones it SHALL force HALT with err_o=1, and it SHALL clear whenever mem_rdy_i=1 or the state changes.
REQ-028 Without CTRLUNIT_MC_WAIT_EN, mem_rdy_i SHALL be ignored and treated as 1, the counter SHALL be absent, and err_o SHALL be 0 except in the illegal-state case.

Structure
REQ-029 Package ctrlunit_pkg SHALL hold the state enum, the opcode constants and the alu_op constants.
REQ-030 The output decode SHALL be a sub-module ctrlunit_dec (state, op_q, flags -> strobes); the FSM and timeout logic SHALL stay in ctrlunit_mc.

Verification
REQ-031 Reset, run_i=1, op_i=0 (ADD), mem_rdy_i=1 -> FETCH, DECODE, EXEC, WB; acc_ld_o=1 with alu_op_o=01 in cycle 4, then FETCH.
REQ-032 op_i=5 (JZ) with zf_i=0, then again with zf_i=1 -> jmp_o=0 on the first pass, jmp_o=1 for one EXEC cycle on the second; 3 cycles each.
REQ-033 op_i=3 (STA) with mem_rdy_i low for 3 cycles -> mw_o=1 held for 4 EXEC cycles, mr_o=0 throughout.
REQ-034 With CTRLUNIT_MC_WAIT_EN, TMO_W=4 and mem_rdy_i=0 in FETCH -> HALT and err_o=1 after 15 wait cycles.
REQ-035 op_i=7 (HLT) -> halt_o=1 and it stays 1; rst_i pulsed asynchronously mid-WB -> all outputs 0 immediately, state_o=0.

Source files
------------

// File: rtl/ctrlunit_pkg.sv
// Shared types for the multi-cycle control unit: FSM state encoding, opcode map
// and ALU operation codes.
package ctrlunit_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_e;

  // Opcodes are compared zero-extended to the widest legal opcode (6 bits).
  localparam logic [5:0] OPC_ADD = 6'd0;
  localparam logic [5:0] OPC_SUB = 6'd1;
  localparam logic [5:0] OPC_LDA = 6'd2;
  localparam logic [5:0] OPC_STA = 6'd3;
  localparam logic [5:0] OPC_JMP = 6'd4;
  localparam logic [5:0] OPC_JZ  = 6'd5;
  localparam logic [5:0] OPC_JC  = 6'd6;
  localparam logic [5:0] OPC_HLT = 6'd7;
  localparam logic [5:0] OPC_AND = 6'd8;

  localparam logic [1:0] ALU_PASS = 2'b00;
  localparam logic [1:0] ALU_ADD  = 2'b01;
  localparam logic [1:0] ALU_SUB  = 2'b10;
  localparam logic [1:0] ALU_AND  = 2'b11;

  function automatic logic op_loads_acc(input logic [5:0] op);
    return (op == OPC_ADD) || (op == OPC_SUB) || (op == OPC_LDA) || (op == OPC_AND);
  endfunction

  function automatic logic [1:0] alu_sel(input logic [5:0] op);
    case (op)
      OPC_ADD: return ALU_ADD;
      OPC_SUB: return ALU_SUB;
      OPC_AND: return ALU_AND;
      default: return ALU_PASS;
    endcase
  endfunction

endpackage

// File: rtl/ctrlunit_dec.sv
// Output decode for the control unit: strobes from the current state and the
// latched opcode; only pc_inc_o and jmp_o look at memory-ready and the flags.
module ctrlunit_dec
  import ctrlunit_pkg::*;
#(
  parameter int OP_W = 4
) (
  input  state_e          state_i,
  input  logic [OP_W-1:0] op_i,
  input  logic            rdy_i,
  input  logic            zf_i,
  input  logic            cf_i,
  output logic            mr_o,
  output logic            mw_o,
  output logic            ir_ld_o,
  output logic            pc_inc_o,
  output logic            jmp_o,
  output logic            acc_ld_o,
  output logic            halt_o,
  output logic [1:0]      alu_op_o
);

  logic [5:0] op_ext;
  assign op_ext = 6'(op_i);

  always_comb begin
    mr_o     = 1'b0;
    mw_o     = 1'b0;
    ir_ld_o  = 1'b0;
    pc_inc_o = 1'b0;
    jmp_o    = 1'b0;
    acc_ld_o = 1'b0;
    halt_o   = 1'b0;
    alu_op_o = ALU_PASS;
    case (state_i)
      S_FETCH: begin
        mr_o     = 1'b1;
        ir_ld_o  = 1'b1;
        pc_inc_o = rdy_i;
      end
      S_EXEC: begin
        case (op_ext)
          OPC_ADD, OPC_SUB, OPC_LDA, OPC_AND: mr_o = 1'b1;
          OPC_STA: mw_o  = 1'b1;
          OPC_JMP: jmp_o = 1'b1;
          OPC_JZ:  jmp_o = zf_i;
          OPC_JC:  jmp_o = cf_i;
          default: ;
        endcase
      end
      S_WB: begin
        acc_ld_o = 1'b1;
        alu_op_o = alu_sel(op_ext);
      end
      S_HALT:  halt_o = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/ctrlunit_mc.sv
// Multi-cycle control unit FSM with optional memory wait-timeout counter
// (enabled by defining CTRLUNIT_MC_WAIT_EN).
module ctrlunit_mc
  import ctrlunit_pkg::*;
#(
  parameter int OP_W  = 4,
  parameter int TMO_W = 4
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            run_i,
  input  logic [OP_W-1:0] op_i,
  input  logic            zf_i,
  input  logic            cf_i,
  input  logic            mem_rdy_i,
  output logic            mr_o,
  output logic            mw_o,
  output logic            ir_ld_o,
  output logic            pc_inc_o,
  output logic            jmp_o,
  output logic            acc_ld_o,
  output logic [1:0]      alu_op_o,
  output logic            halt_o,
  output logic            err_o,
  output logic [2:0]      state_o
);

  state_e          state_q;
  logic [OP_W-1:0] op_q;
  logic            err_q;
  logic            rdy;
  logic            tmo_hit;
  logic [5:0]      op_ext;

  assign op_ext = 6'(op_q);

`ifdef CTRLUNIT_MC_WAIT_EN
  logic [TMO_W-1:0] tmo_q;
  logic [TMO_W-1:0] tmo_d;
  logic             waiting;

  assign rdy     = mem_rdy_i;
  assign waiting = !mem_rdy_i &&
                   ((state_q == S_FETCH) ||
                    ((state_q == S_EXEC) && (op_loads_acc(op_ext) || (op_ext == OPC_STA))));
  assign tmo_d   = tmo_q + TMO_W'(1);
  assign tmo_hit = waiting && (&tmo_d);

  // Leaving the wait (ready, state change or timeout) always restarts the count.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)
      tmo_q <= '0;
    else if (waiting && !tmo_hit)
      tmo_q <= tmo_d;
    else
      tmo_q <= '0;
  end
`else
  // Memory is treated as always ready; the term keeps both inputs referenced.
  assign rdy     = mem_rdy_i | (TMO_W != 0);
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      err_q   <= 1'b0;
    end else if (tmo_hit) begin
      state_q <= S_HALT;
      err_q   <= 1'b1;
    end else begin
      case (state_q)
        S_IDLE:   if (run_i) state_q <= S_FETCH;
        S_FETCH:  if (rdy) state_q <= S_DECODE;
        S_DECODE: begin
          op_q    <= op_i;
          state_q <= S_EXEC;
        end
        S_EXEC: begin
          if (op_loads_acc(op_ext)) begin
            if (rdy) state_q <= S_WB;
          end else if (op_ext == OPC_STA) begin
            if (rdy) state_q <= S_FETCH;
          end else if (op_ext == OPC_HLT) begin
            state_q <= S_HALT;
          end else begin
            state_q <= S_FETCH;
          end
        end
        S_WB:     state_q <= S_FETCH;
        S_HALT:   state_q <= S_HALT;
        default: begin
          state_q <= S_HALT;
          err_q   <= 1'b1;
        end
      endcase
    end
  end

  ctrlunit_dec #(
    .OP_W(OP_W)
  ) u_dec (
    .state_i  (state_q),
    .op_i     (op_q),
    .rdy_i    (rdy),
    .zf_i     (zf_i),
    .cf_i     (cf_i),
    .mr_o     (mr_o),
    .mw_o     (mw_o),
    .ir_ld_o  (ir_ld_o),
    .pc_inc_o (pc_inc_o),
    .jmp_o    (jmp_o),
    .acc_ld_o (acc_ld_o),
    .halt_o   (halt_o),
    .alu_op_o (alu_op_o)
  );

  assign err_o   = err_q;
  assign state_o = state_q;

endmodule

// File: tb/tb_ctrlunit_mc.sv
// Scoreboard bench for ctrlunit_mc: each step queues the inputs for one cycle
// and the full expected output vector, which is popped and compared that cycle.
module tb_ctrlunit_mc;

  localparam int OP_W = 4;

  logic            clk = 1'b0;
  logic            rst_i = 1'b1;
  logic            run_i = 1'b0;
  logic [OP_W-1:0] op_i = '0;
  logic            zf_i = 1'b0;
  logic            cf_i = 1'b0;
  logic            mem_rdy_i = 1'b1;
  logic            mr_o, mw_o, ir_ld_o, pc_inc_o, jmp_o, acc_ld_o, halt_o, err_o;
  logic [1:0]      alu_op_o;
  logic [2:0]      state_o;

  // {state, mr, mw, ir_ld, pc_inc, jmp, acc_ld, halt, err, alu_op}
  logic [12:0] obs;
  assign obs = {state_o, mr_o, mw_o, ir_ld_o, pc_inc_o, jmp_o, acc_ld_o, halt_o, err_o, alu_op_o};

  localparam logic [7:0] F_RDY  = 8'b1011_0000;
  localparam logic [7:0] F_WAIT = 8'b1010_0000;
  localparam logic [7:0] X_RD   = 8'b1000_0000;
  localparam logic [7:0] X_WR   = 8'b0100_0000;
  localparam logic [7:0] X_JMP  = 8'b0000_1000;
  localparam logic [7:0] WB_S   = 8'b0000_0100;
  localparam logic [7:0] H_S    = 8'b0000_0010;
  localparam logic [7:0] H_ERR  = 8'b0000_0011;
  localparam logic [7:0] NONE   = 8'h00;

  typedef struct {
    logic [OP_W-1:0] op;
    logic            rdy;
    logic            zf;
    logic            cf;
    logic [12:0]     exp;
  } step_t;

  step_t sb_q[$];
  int total = 0;
  int bad   = 0;

  ctrlunit_mc #(.OP_W(OP_W), .TMO_W(4)) dut (
    .clk_i     (clk),
    .rst_i     (rst_i),
    .run_i     (run_i),
    .op_i      (op_i),
    .zf_i      (zf_i),
    .cf_i      (cf_i),
    .mem_rdy_i (mem_rdy_i),
    .mr_o      (mr_o),
    .mw_o      (mw_o),
    .ir_ld_o   (ir_ld_o),
    .pc_inc_o  (pc_inc_o),
    .jmp_o     (jmp_o),
    .acc_ld_o  (acc_ld_o),
    .alu_op_o  (alu_op_o),
    .halt_o    (halt_o),
    .err_o     (err_o),
    .state_o   (state_o)
  );

  always #5 clk = ~clk;

  function automatic logic [12:0] ev(input logic [2:0] st, input logic [7:0] sb, input logic [1:0] alu);
    return {st, sb, alu};
  endfunction

  task automatic push(input logic [OP_W-1:0] op, input logic rdy, input logic zf, input logic cf,
                      input logic [12:0] e);
    step_t s;
    s.op = op; s.rdy = rdy; s.zf = zf; s.cf = cf; s.exp = e;
    sb_q.push_back(s);
  endtask

  // Queue the FETCH and DECODE cycles common to every instruction (no waits).
  task automatic push_fd(input logic [OP_W-1:0] op);
    push(op, 1'b1, 1'b0, 1'b0, ev(3'd1, F_RDY, 2'b00));
    push(op, 1'b1, 1'b0, 1'b0, ev(3'd2, NONE, 2'b00));
  endtask

  // Reset pulse between clock edges, leaving run_i=1 so the next edge enters FETCH.
  task automatic do_rst();
    @(posedge clk); #2;
    rst_i = 1'b1; run_i = 1'b0; mem_rdy_i = 1'b1; zf_i = 1'b0; cf_i = 1'b0;
    #1;
    rst_i = 1'b0; run_i = 1'b1;
  endtask

  task automatic test_reset();
    #3;
    total++;
    if (obs !== 13'd0) begin
      bad++; $display("FAIL reset_initial: got %b want %b", obs, 13'd0);
    end
    run_i = 1'b1;
    repeat (2) @(posedge clk);
    #3;
    total++;
    if (obs !== 13'd0) begin
      bad++; $display("FAIL reset_held_with_run: got %b want %b", obs, 13'd0);
    end
    @(posedge clk); #2;
    run_i = 1'b0; rst_i = 1'b0;
    push(4'd0, 1'b1, 1'b0, 1'b0, 13'd0);
    push(4'd0, 1'b1, 1'b0, 1'b0, 13'd0);
    while (sb_q.size() > 0) begin
      step_t s = sb_q.pop_front();
      @(posedge clk); #2;
      op_i = s.op; mem_rdy_i = s.rdy; zf_i = s.zf; cf_i = s.cf;
      #1;
      total++;
      if (obs !== s.exp) begin
        bad++; $display("FAIL idle_no_run: got %b want %b", obs, s.exp);
      end
    end
    $display("reset: idle checks done");
  endtask

  task automatic test_alu();
    logic [OP_W-1:0] ops[4]  = '{4'd0, 4'd1, 4'd8, 4'd2};
    logic [1:0]      alus[4] = '{2'b01, 2'b10, 2'b11, 2'b00};
    for (int i = 0; i < 4; i++) begin
      do_rst();
      op_i = ops[i];
      push_fd(ops[i]);
      push(ops[i], 1'b1, 1'b0, 1'b0, ev(3'd3, X_RD, 2'b00));
      push(ops[i], 1'b1, 1'b0, 1'b0, ev(3'd4, WB_S, alus[i]));
      push(ops[i], 1'b1, 1'b0, 1'b0, ev(3'd1, F_RDY, 2'b00));
      while (sb_q.size() > 0) begin
        step_t s = sb_q.pop_front();
        @(posedge clk); #2;
        op_i = s.op; mem_rdy_i = s.rdy; zf_i = s.zf; cf_i = s.cf;
        #1;
        total++;
        if (obs !== s.exp) begin
          bad++; $display("FAIL alu_op%0d: got %b want %b", ops[i], obs, s.exp);
        end
      end
      $display("alu: op %0d sequence checked", ops[i]);
    end
  endtask

  task automatic test_jumps();
    logic [OP_W-1:0] ops[6] = '{4'd5, 4'd5, 4'd6, 4'd6, 4'd4, 4'd5};
    logic            zfs[6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic            cfs[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    logic            tk[6]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    do_rst();
    op_i = ops[0];
    for (int i = 0; i < 6; i++) begin
      push_fd(ops[i]);
      push(ops[i], 1'b1, zfs[i], cfs[i], ev(3'd3, tk[i] ? X_JMP : NONE, 2'b00));
    end
    push(4'd0, 1'b1, 1'b0, 1'b0, ev(3'd1, F_RDY, 2'b00));
    while (sb_q.size() > 0) begin
      step_t s = sb_q.pop_front();
      @(posedge clk); #2;
      op_i = s.op; mem_rdy_i = s.rdy; zf_i = s.zf; cf_i = s.cf;
      #1;
      total++;
      if (obs !== s.exp) begin
        bad++; $display("FAIL jump op%0d zf%0b cf%0b: got %b want %b", s.op, s.zf, s.cf, obs, s.exp);
      end
    end
    $display("jumps: JZ/JC/JMP sequence checked");
  endtask

  task automatic test_sta_nop();
    do_rst();
    op_i = 4'd3;
    push_fd(4'd3);
`ifdef CTRLUNIT_MC_WAIT_EN
    for (int i = 0; i < 3; i++) push(4'd3, 1'b0, 1'b0, 1'b0, ev(3'd3, X_WR, 2'b00));
    push(4'd3, 1'b1, 1'b0, 1'b0, ev(3'd3, X_WR, 2'b00));
`else
    push(4'd3, 1'b0, 1'b0, 1'b0, ev(3'd3, X_WR, 2'b00));
`endif
    // A NOP opcode follows: three cycles with no EXEC strobes.
    push(4'd9, 1'b1, 1'b0, 1'b0, ev(3'd1, F_RDY, 2'b00));
    push(4'd9, 1'b1, 1'b0, 1'b0, ev(3'd2, NONE, 2'b00));
    push(4'd9, 1'b1, 1'b0, 1'b0, ev(3'd3, NONE, 2'b00));
    push(4'd9, 1'b1, 1'b0, 1'b0, ev(3'd1, F_RDY, 2'b00));
    while (sb_q.size() > 0) begin
      step_t s = sb_q.pop_front();
      @(posedge clk); #2;
      op_i = s.op; mem_rdy_i = s.rdy; zf_i = s.zf; cf_i = s.cf;
      #1;
      total++;
      if (obs !== s.exp) begin
        bad++; $display("FAIL sta_nop op%0d rdy%0b: got %b want %b", s.op, s.rdy, obs, s.exp);
      end
    end
    $display("sta_nop: store with waits and NOP checked");
  endtask

  task automatic test_fetch_wait();
    do_rst();
    op_i = 4'd12;
`ifdef CTRLUNIT_MC_WAIT_EN
    for (int i = 0; i < 15; i++) push(4'd12, 1'b0, 1'b0, 1'b0, ev(3'd1, F_WAIT, 2'b00));
    push(4'd12, 1'b1, 1'b0, 1'b0, ev(3'd5, H_ERR, 2'b00));
    push(4'd12, 1'b1, 1'b0, 1'b0, ev(3'd5, H_ERR, 2'b00));
`else
    push(4'd12, 1'b0, 1'b0, 1'b0, ev(3'd1, F_RDY, 2'b00));
    push(4'd12, 1'b0, 1'b0, 1'b0, ev(3'd2, NONE, 2'b00));
    push(4'd12, 1'b0, 1'b0, 1'b0, ev(3'd3, NONE, 2'b00));
    push(4'd12, 1'b0, 1'b0, 1'b0, ev(3'd1, F_RDY, 2'b00));
`endif
    while (sb_q.size() > 0) begin
      step_t s = sb_q.pop_front();
      @(posedge clk); #2;
      op_i = s.op; mem_rdy_i = s.rdy; zf_i = s.zf; cf_i = s.cf;
      #1;
      total++;
      if (obs !== s.exp) begin
        bad++; $display("FAIL fetch_wait rdy%0b: got %b want %b", s.rdy, obs, s.exp);
      end
    end
    $display("fetch_wait: memory-ready handling checked");
  endtask

  task automatic test_halt_and_abort();
    do_rst();
    op_i = 4'd7;
    push_fd(4'd7);
    push(4'd7, 1'b1, 1'b0, 1'b0, ev(3'd3, NONE, 2'b00));
    for (int i = 0; i < 3; i++) push(4'd0, 1'b1, 1'b1, 1'b1, ev(3'd5, H_S, 2'b00));
    while (sb_q.size() > 0) begin
      step_t s = sb_q.pop_front();
      @(posedge clk); #2;
      op_i = s.op; mem_rdy_i = s.rdy; zf_i = s.zf; cf_i = s.cf;
      #1;
      total++;
      if (obs !== s.exp) begin
        bad++; $display("FAIL halt: got %b want %b", obs, s.exp);
      end
    end
    $display("halt: HLT sequence checked");

    do_rst();
    op_i = 4'd0;
    push_fd(4'd0);
    push(4'd0, 1'b1, 1'b0, 1'b0, ev(3'd3, X_RD, 2'b00));
    push(4'd0, 1'b1, 1'b0, 1'b0, ev(3'd4, WB_S, 2'b01));
    while (sb_q.size() > 0) begin
      step_t s = sb_q.pop_front();
      @(posedge clk); #2;
      op_i = s.op; mem_rdy_i = s.rdy; zf_i = s.zf; cf_i = s.cf;
      #1;
      total++;
      if (obs !== s.exp) begin
        bad++; $display("FAIL abort_lead: got %b want %b", obs, s.exp);
      end
    end
    #1 rst_i = 1'b1;
    #1;
    total++;
    if (obs !== 13'd0) begin
      bad++; $display("FAIL abort_async: got %b want %b", obs, 13'd0);
    end
    @(posedge clk); #2;
    run_i = 1'b0; rst_i = 1'b0;
    push(4'd0, 1'b1, 1'b0, 1'b0, 13'd0);
    push(4'd0, 1'b1, 1'b0, 1'b0, 13'd0);
    while (sb_q.size() > 0) begin
      step_t s = sb_q.pop_front();
      @(posedge clk); #2;
      op_i = s.op; mem_rdy_i = s.rdy; zf_i = s.zf; cf_i = s.cf;
      #1;
      total++;
      if (obs !== s.exp) begin
        bad++; $display("FAIL abort_needs_run: got %b want %b", obs, s.exp);
      end
    end
    $display("abort: asynchronous reset mid-WB checked");
  endtask

  task automatic test_back_to_back();
    do_rst();
    op_i = 4'd2;
    push_fd(4'd2);
    push(4'd2, 1'b1, 1'b0, 1'b0, ev(3'd3, X_RD, 2'b00));
    push(4'd2, 1'b1, 1'b0, 1'b0, ev(3'd4, WB_S, 2'b00));
    push_fd(4'd6);
    push(4'd6, 1'b1, 1'b0, 1'b1, ev(3'd3, X_JMP, 2'b00));
    push_fd(4'd1);
    push(4'd1, 1'b1, 1'b0, 1'b0, ev(3'd3, X_RD, 2'b00));
    push(4'd1, 1'b1, 1'b0, 1'b0, ev(3'd4, WB_S, 2'b10));
    push(4'd1, 1'b1, 1'b0, 1'b0, ev(3'd1, F_RDY, 2'b00));
    while (sb_q.size() > 0) begin
      step_t s = sb_q.pop_front();
      @(posedge clk); #2;
      op_i = s.op; mem_rdy_i = s.rdy; zf_i = s.zf; cf_i = s.cf;
      #1;
      total++;
      if (obs !== s.exp) begin
        bad++; $display("FAIL back_to_back op%0d: got %b want %b", s.op, obs, s.exp);
      end
    end
    $display("back_to_back: LDA/JC/SUB program checked");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_alu();
    test_jumps();
    test_sta_nop();
    test_fetch_wait();
    test_halt_and_abort();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
